// File: rtl/hash_mem_responder_if.sv
// Bus bundle between the hash core / host side (master) and the memory responder (slave).
// Carries the core word-memory port, the host load/readback port and the run handshake.
`timescale 1ns/1ps
interface hash_mem_responder_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;
    logic              host_valid;
    logic              host_ready;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [31:0]       host_wdata;
    logic [31:0]       host_rdata;
    logic              host_rvalid;
    logic              host_go;
    logic [ADDR_W-1:0] out_base;
    logic              core_start;
    logic              core_done;
    logic              run_done;
    logic [7:0]        wr_count;
    logic              err_oob;
    logic              err_dup;

    modport slave (
        input  mem_addr, mem_we, mem_write_data,
        input  host_valid, host_we, host_addr, host_wdata, host_go, out_base, core_done,
        output mem_read_data, host_ready, host_rdata, host_rvalid,
        output core_start, run_done, wr_count, err_oob, err_dup
    );

    modport master (
        output mem_addr, mem_we, mem_write_data,
        output host_valid, host_we, host_addr, host_wdata, host_go, out_base, core_done,
        input  mem_read_data, host_ready, host_rdata, host_rvalid,
        input  core_start, run_done, wr_count, err_oob, err_dup
    );
endinterface

// File: rtl/hash_mem_responder.sv
// Memory-side responder for the SHA-256 core: host load/readback in IDLE, core-only access in SERVE.
// Optional duplicate-write detection over the result window: HMR_DUP_WRITE_CHECK_EN.
`timescale 1ns/1ps
module hash_mem_responder #(
    parameter int          ADDR_W    = 16,
    parameter int          DEPTH     = 256,
    parameter int          OUT_WORDS = 16,
    parameter logic [31:0] OOB_DATA  = 32'hDEADBEEF
) (
    input  logic                clk_i,
    input  logic                reset_i,
    hash_mem_responder_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] OUT_WORDS_X = (ADDR_W + 1)'(OUT_WORDS);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_SERVE = 2'd2;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_X);
    endfunction

    logic [1:0]        state_q, state_d;
    logic              host_ready_q, core_start_q, run_done_q, host_rvalid_q;
    logic              busy_seen_q, err_oob_q;
    logic [31:0]       host_rdata_q, mem_rdata_q;
    logic [ADDR_W-1:0] out_base_q;
    logic [7:0]        wr_count_q, wr_count_d;
    logic [31:0]       ram_q [DEPTH];

    logic              host_acc_s, host_wr_s, host_rd_s, go_s, serve_s, core_wr_s, done_s;
    logic              host_inr_s, core_inr_s, in_win_s, count_en_s;
    logic [ADDR_W:0]   core_offs_s;
    logic [IDX_W-1:0]  host_idx_s, core_idx_s;

    assign host_acc_s  = bus.host_valid & host_ready_q;
    assign host_wr_s   = host_acc_s & bus.host_we;
    assign host_rd_s   = host_acc_s & ~bus.host_we;
    assign go_s        = bus.host_go & (state_q == ST_IDLE);
    assign serve_s     = (state_q == ST_SERVE);
    assign core_wr_s   = serve_s & bus.mem_we;
    assign done_s      = serve_s & bus.core_done & busy_seen_q;
    assign host_inr_s  = in_range(bus.host_addr);
    assign core_inr_s  = in_range(bus.mem_addr);
    assign host_idx_s  = bus.host_addr[IDX_W-1:0];
    assign core_idx_s  = bus.mem_addr[IDX_W-1:0];
    // One extra bit so out_base + OUT_WORDS never wraps.
    assign core_offs_s = {1'b0, bus.mem_addr} - {1'b0, out_base_q};
    assign in_win_s    = ({1'b0, bus.mem_addr} >= {1'b0, out_base_q}) && (core_offs_s < OUT_WORDS_X);

`ifdef HMR_DUP_WRITE_CHECK_EN
    logic [OUT_WORDS-1:0] bitmap_q, bitmap_d;
    logic                 err_dup_q, err_dup_d;
    logic [$clog2(OUT_WORDS)-1:0] win_idx_s;

    assign win_idx_s  = core_offs_s[$clog2(OUT_WORDS)-1:0];
    assign count_en_s = ~bitmap_q[win_idx_s];

    // Per-word written map for the result window; a repeat write raises err_dup.
    always_comb begin
        bitmap_d  = bitmap_q;
        err_dup_d = err_dup_q;
        if (go_s) begin
            bitmap_d  = '0;
            err_dup_d = 1'b0;
        end else if (core_wr_s && in_win_s) begin
            if (bitmap_q[win_idx_s]) begin
                err_dup_d = 1'b1;
            end else begin
                bitmap_d[win_idx_s] = 1'b1;
            end
        end else begin
            bitmap_d  = bitmap_q;
        end
    end

    // Duplicate-write tracking registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bitmap_q  <= '0;
            err_dup_q <= 1'b0;
        end else begin
            bitmap_q  <= bitmap_d;
            err_dup_q <= err_dup_d;
        end
    end

    assign bus.err_dup = err_dup_q;
`else
    assign count_en_s  = 1'b1;
    assign bus.err_dup = 1'b0;
`endif

    // Run sequencing: IDLE -> START (one cycle) -> SERVE until the core reports done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = go_s ? ST_START : ST_IDLE;
            ST_START: state_d = ST_SERVE;
            ST_SERVE: state_d = done_s ? ST_IDLE : ST_SERVE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Saturating count of core writes landing in the result window.
    always_comb begin
        wr_count_d = wr_count_q;
        if (go_s) begin
            wr_count_d = 8'd0;
        end else if (core_wr_s && in_win_s && count_en_s && (wr_count_q != 8'hFF)) begin
            wr_count_d = wr_count_q + 8'd1;
        end else begin
            wr_count_d = wr_count_q;
        end
    end

    // Control, status and read-data registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            host_ready_q  <= 1'b0;
            core_start_q  <= 1'b0;
            run_done_q    <= 1'b0;
            host_rvalid_q <= 1'b0;
            busy_seen_q   <= 1'b0;
            err_oob_q     <= 1'b0;
            host_rdata_q  <= 32'd0;
            mem_rdata_q   <= 32'd0;
            out_base_q    <= '0;
            wr_count_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            host_ready_q  <= (state_d == ST_IDLE);
            core_start_q  <= (state_d == ST_START);
            run_done_q    <= done_s;
            host_rvalid_q <= host_rd_s;
            wr_count_q    <= wr_count_d;
            if (go_s) begin
                out_base_q <= bus.out_base;
            end
            // The core's done level can still be high right after start; require a busy phase first.
            if (go_s) begin
                busy_seen_q <= 1'b0;
            end else if ((state_q != ST_IDLE) && !bus.core_done) begin
                busy_seen_q <= 1'b1;
            end
            if ((host_acc_s && !host_inr_s) || (serve_s && !core_inr_s)) begin
                err_oob_q <= 1'b1;
            end else if (go_s) begin
                err_oob_q <= 1'b0;
            end
            if (host_rd_s) begin
                host_rdata_q <= host_inr_s ? ram_q[host_idx_s] : OOB_DATA;
            end
            if (serve_s) begin
                mem_rdata_q <= core_inr_s ? ram_q[core_idx_s] : OOB_DATA;
            end
        end
    end

    // Word RAM: host owns it in IDLE, the core in SERVE; out-of-range writes are dropped.
    always_ff @(posedge clk_i) begin
        if (host_wr_s && host_inr_s) begin
            ram_q[host_idx_s] <= bus.host_wdata;
        end else if (core_wr_s && core_inr_s) begin
            ram_q[core_idx_s] <= bus.mem_write_data;
        end
    end

    assign bus.host_ready    = host_ready_q;
    assign bus.host_rdata    = host_rdata_q;
    assign bus.host_rvalid   = host_rvalid_q;
    assign bus.mem_read_data = mem_rdata_q;
    assign bus.core_start    = core_start_q;
    assign bus.run_done      = run_done_q;
    assign bus.wr_count      = wr_count_q;
    assign bus.err_oob       = err_oob_q;
endmodule

// File: tb/tb_hash_mem_responder.sv
// Scoreboard bench for hash_mem_responder: stimulus pushes expected read data, monitors pop and compare.
`timescale 1ns/1ps
module tb_hash_mem_responder;
    localparam int ADDR_W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   run_done_cnt = 0;
    logic core_rd_flag = 1'b0;
    logic core_pend = 1'b0;
    logic host_done = 1'b0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } hexp_t;
    hexp_t       host_q[$];
    logic [31:0] core_q[$];

    hash_mem_responder_if #(.ADDR_W(ADDR_W)) bus();

    hash_mem_responder #(
        .ADDR_W(ADDR_W), .DEPTH(256), .OUT_WORDS(16), .OOB_DATA(32'hDEADBEEF)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Core read issued at a negedge is checked at the negedge after the following posedge.
    always @(posedge clk) core_pend <= core_rd_flag & ~reset;

    always @(negedge clk) begin
        if (bus.run_done === 1'b1) run_done_cnt <= run_done_cnt + 1;
        if (bus.host_rvalid === 1'b1) begin
            if (host_q.size() == 0) begin
                chk("host_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                hexp_t e;
                e = host_q.pop_front();
                chk("host_rdata", bus.host_rdata, e.data);
                chk("host_rvalid_latency", cyc, e.cyc);
            end
        end
        if (core_pend) begin
            if (core_q.size() == 0) begin
                chk("mem_read_unexpected", 32'd1, 32'd0);
            end else begin
                chk("mem_read_data", bus.mem_read_data, core_q.pop_front());
            end
        end
    end

    task automatic host_access(input logic we, input logic [15:0] a, input logic [31:0] d,
                               input logic [31:0] exp_rd);
        int n = 0;
        @(negedge clk);
        bus.host_valid = 1'b1;
        bus.host_we    = we;
        bus.host_addr  = a;
        bus.host_wdata = d;
        while (bus.host_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("host_ready_timeout", 32'd0, 32'd1);
        end else if (!we) begin
            host_q.push_back('{exp_rd, cyc + 1});
        end
        @(posedge clk);
        #1 bus.host_valid = 1'b0;
    endtask

    task automatic run_go(input logic [15:0] base);
        @(negedge clk);
        bus.out_base = base;
        bus.host_go  = 1'b1;
        @(posedge clk);
        #1 bus.host_go = 1'b0;
        @(negedge clk);
        chk("core_start_on", {31'd0, bus.core_start}, 32'd1);
        chk("host_ready_start", {31'd0, bus.host_ready}, 32'd0);
        chk("wr_count_clr", {24'd0, bus.wr_count}, 32'd0);
        bus.core_done = 1'b0;
        @(negedge clk);
        chk("core_start_off", {31'd0, bus.core_start}, 32'd0);
    endtask

    task automatic core_op(input logic we, input logic [15:0] a, input logic [31:0] d,
                           input logic chk_rd, input logic [31:0] exp_rd);
        @(negedge clk);
        chk("host_ready_serve", {31'd0, bus.host_ready}, 32'd0);
        bus.mem_addr       = a;
        bus.mem_we         = we;
        bus.mem_write_data = d;
        core_rd_flag       = chk_rd;
        if (chk_rd) core_q.push_back(exp_rd);
    endtask

    task automatic finish_run();
        int n = 0;
        @(negedge clk);
        bus.mem_we    = 1'b0;
        core_rd_flag  = 1'b0;
        bus.core_done = 1'b1;
        @(negedge clk);
        while (bus.run_done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("run_done_seen", {31'd0, bus.run_done}, 32'd1);
        @(negedge clk);
        chk("run_done_pulse", {31'd0, bus.run_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bus.mem_addr = 16'd0;   bus.mem_we = 1'b0;   bus.mem_write_data = 32'd0;
        bus.host_valid = 1'b0;  bus.host_we = 1'b0;  bus.host_addr = 16'd0;
        bus.host_wdata = 32'd0; bus.host_go = 1'b0;  bus.out_base = 16'd0;
        bus.core_done = 1'b1;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_read_data", bus.mem_read_data, 32'd0);
        chk("rst_host_ready", {31'd0, bus.host_ready}, 32'd0);
        chk("rst_host_rdata", bus.host_rdata, 32'd0);
        chk("rst_host_rvalid", {31'd0, bus.host_rvalid}, 32'd0);
        chk("rst_core_start", {31'd0, bus.core_start}, 32'd0);
        chk("rst_run_done", {31'd0, bus.run_done}, 32'd0);
        chk("rst_wr_count", {24'd0, bus.wr_count}, 32'd0);
        chk("rst_err_oob", {31'd0, bus.err_oob}, 32'd0);
        chk("rst_err_dup", {31'd0, bus.err_dup}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_host_ready", {31'd0, bus.host_ready}, 32'd1);

        // Host load and readback
        for (int i = 0; i < 20; i++) host_access(1'b1, 16'(i), 32'h0000_1000 + 32'(i), 32'd0);
        host_access(1'b1, 16'd44, 32'h5555_0044, 32'd0);
        host_access(1'b0, 16'd5, 32'd0, 32'h0000_1005);

        // Run 1: reads, read-before-write, out-of-range, window boundaries, host stall
        run_go(16'h0040);
        core_op(1'b0, 16'd3,   32'd0, 1'b1, 32'h0000_1003);
        core_op(1'b0, 16'd19,  32'd0, 1'b1, 32'h0000_1013);
        core_op(1'b1, 16'd10,  32'hCAFE_000A, 1'b1, 32'h0000_100A);
        core_op(1'b0, 16'd10,  32'd0, 1'b1, 32'hCAFE_000A);
        core_op(1'b0, 16'd300, 32'd0, 1'b1, 32'hDEAD_BEEF);
        core_op(1'b1, 16'd300, 32'h1234_5678, 1'b0, 32'd0);
        core_op(1'b0, 16'd44,  32'd0, 1'b1, 32'h5555_0044);
        core_op(1'b1, 16'h003F, 32'h3F3F_3F3F, 1'b0, 32'd0);
        core_op(1'b1, 16'h0050, 32'h5050_5050, 1'b0, 32'd0);
        host_done = 1'b0;
        fork
            begin
                host_access(1'b0, 16'h004F, 32'd0, 32'hA000_000F);
                host_done = 1'b1;
            end
        join_none
        for (int i = 0; i < 16; i++) core_op(1'b1, 16'h0040 + 16'(i), 32'hA000_0000 + 32'(i), 1'b0, 32'd0);
        finish_run();
        chk("run1_wr_count", {24'd0, bus.wr_count}, 32'd16);
        chk("run1_err_oob", {31'd0, bus.err_oob}, 32'd1);
        chk("run1_err_dup", {31'd0, bus.err_dup}, 32'd0);
        n = 0;
        while (!host_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stalled_host_done", {31'd0, host_done}, 32'd1);
        chk("run1_run_done_cnt", run_done_cnt, 32'd1);

        // mem_read_data holds outside SERVE
        @(negedge clk);
        bus.mem_addr = 16'd3;
        repeat (2) @(negedge clk);
        chk("mem_read_hold_idle", bus.mem_read_data, 32'hA000_000F);
        host_access(1'b0, 16'd44, 32'd0, 32'h5555_0044);
        host_access(1'b0, 16'd10, 32'd0, 32'hCAFE_000A);

        // Reset in the middle of SERVE
        run_go(16'h0040);
        chk("go_clears_err_oob", {31'd0, bus.err_oob}, 32'd0);
        core_op(1'b1, 16'h0040, 32'h1111_0040, 1'b0, 32'd0);
        core_op(1'b1, 16'h0041, 32'h1111_0041, 1'b0, 32'd0);
        @(negedge clk);
        bus.mem_we = 1'b0;
        chk("mid_wr_count", {24'd0, bus.wr_count}, 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("midrst_wr_count", {24'd0, bus.wr_count}, 32'd0);
        chk("midrst_host_ready", {31'd0, bus.host_ready}, 32'd0);
        chk("midrst_core_start", {31'd0, bus.core_start}, 32'd0);
        chk("midrst_mem_read_data", bus.mem_read_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.core_done = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_run_done_cnt", run_done_cnt, 32'd1);
        chk("midrst_idle_ready", {31'd0, bus.host_ready}, 32'd1);

        // Rerun with a repeated write to 0x42
        run_go(16'h0040);
        for (int i = 0; i < 16; i++) core_op(1'b1, 16'h0040 + 16'(i), 32'hB000_0000 + 32'(i), 1'b0, 32'd0);
        core_op(1'b1, 16'h0042, 32'hBBBB_0042, 1'b0, 32'd0);
        finish_run();
`ifdef HMR_DUP_WRITE_CHECK_EN
        chk("dup_err_dup", {31'd0, bus.err_dup}, 32'd1);
        chk("dup_wr_count", {24'd0, bus.wr_count}, 32'd16);
`else
        chk("dup_err_dup", {31'd0, bus.err_dup}, 32'd0);
        chk("dup_wr_count", {24'd0, bus.wr_count}, 32'd17);
`endif
        chk("rerun_run_done_cnt", run_done_cnt, 32'd2);
        host_access(1'b0, 16'h0042, 32'd0, 32'hBBBB_0042);

        // Host out-of-range read
        host_access(1'b0, 16'd300, 32'd0, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("host_oob_err", {31'd0, bus.err_oob}, 32'd1);

        n = 0;
        while ((host_q.size() != 0 || core_q.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", host_q.size() + core_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hash_mem_responder.md
Name: hash_mem_responder

Overview:
- Memory-side responder for the SHA-256/bitcoin hash core's word-addressed memory interface. The core is the master; this block is the slave.
- Services the core's reads of message words and captures its writes of hash results.
- Gives the testbench/host a load/readback port and a start/complete handshake.
- Sits between the host (or bench) and the hash core. Replaces the ad-hoc behavioural dual-port SRAM.

Parameters:
- ADDR_W, 16, width of the word address on both ports.
- DEPTH, 256, number of 32-bit words stored; valid addresses are 0..DEPTH-1.
- OUT_WORDS, 16, number of result words expected from the core per run.
- OOB_DATA, 32'hDEADBEEF, read data returned for out-of-range addresses.

Ports:
- clk  in  1  single clock; the core's mem_clk is driven from the same net.
- reset  in  1  asynchronous, active-high.
- mem_addr  in  ADDR_W  core word address.
- mem_we  in  1  core write enable.
- mem_write_data  in  32  core write data.
- mem_read_data  out  32  registered read data to core.
- host_valid  in  1  host access request.
- host_ready  out  1  host access accepted this cycle.
- host_we  in  1  host write (1) / read (0).
- host_addr  in  ADDR_W  host word address.
- host_wdata  in  32  host write data.
- host_rdata  out  32  host read data.
- host_rvalid  out  1  host_rdata valid.
- host_go  in  1  pulse; launch a hash run.
- out_base  in  ADDR_W  first result address; sampled on an accepted host_go.
- core_start  out  1  start pulse to the core.
- core_done  in  1  core done level; high while the core is idle.
- run_done  out  1  one-cycle pulse at the end of a run.
- wr_count  out  8  in-window core writes this run.
- err_oob  out  1  sticky out-of-range access flag.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; wr_count 0; err_oob 0. RAM contents are not reset.

States and transitions:
- IDLE:
  - host_ready=1.
  - Accepted host write (host_valid & host_we) updates the RAM at the clock edge.
  - Accepted host read returns host_rdata with host_rvalid=1 exactly one cycle later.
  - host_go in IDLE: latch out_base, clear wr_count and busy_seen, go to START. host_go is ignored in every other state.
  - host_valid and host_go in the same cycle: the access completes, then the block moves to START.
- START (1 cycle): core_start=1, host_ready=0, then go to SERVE.
- SERVE:
  - host_ready=0. Host requests stall and are not dropped. Only the core accesses the RAM.
  - mem_read_data is registered with 1-cycle latency: the address present at edge N gives data valid after edge N. The core relies on exactly this latency; no bypass.
  - Core write with mem_we=1: the RAM is written, and mem_read_data that cycle returns the old contents (read-before-write).
  - A core write with out_base <= mem_addr < out_base+OUT_WORDS increments wr_count, saturating at 255.
  - busy_seen sets when core_done=0. This guards against the core's done level still being high in the first cycles after start.
  - core_done=1 with busy_seen=1: run_done=1 for one cycle, then go to IDLE.

Out-of-range accesses (addr >= DEPTH, either port):
- Reads return OOB_DATA.
- Writes are dropped.
- err_oob is set and stays set until reset or the next accepted host_go.

Other rules:
- Window arithmetic is ADDR_W+1 bits wide, so out_base+OUT_WORDS does not wrap.
- Reset mid-run: the block returns to IDLE immediately and clears all flags. A pending core_start is withdrawn.
- The host port read pipeline is independent of mem_read_data. mem_read_data holds its last value outside SERVE.

Optional Feature:
- Macro: HMR_DUP_WRITE_CHECK_EN.
- When defined:
  - A per-word written bitmap of OUT_WORDS bits is cleared on host_go.
  - A second core write to the same window word sets a sticky output err_dup (1 bit).
  - wr_count counts distinct words only.
- When undefined: the bitmap is absent, err_dup is tied to 0, and wr_count counts every in-window write.

Test Plan:
- Host writes 0x1000+i to addresses 0..19; then host read of address 5 -> host_rvalid exactly one cycle later with host_rdata=0x00001005.
- Host_go with out_base=0x40 -> core_start high for exactly one cycle; the core reading address 3 sees 0x00001003 one cycle after mem_addr=3.
- Core writes 0xA0000000+n to 0x40..0x4F, then core_done rises -> wr_count=16, one run_done pulse; host reads 0x4F -> 0xA000000F.
- Host_valid held during SERVE -> host_ready=0 throughout; the access completes in IDLE after run_done, with correct data.
- Core reads address 300 (DEPTH=256) -> mem_read_data=0xDEADBEEF, err_oob=1; the core writes address 300 and RAM is unchanged.
- Reset asserted mid-SERVE -> state IDLE, wr_count=0, run_done never pulses. With HMR_DUP_WRITE_CHECK_EN, a rerun writing 0x42 twice -> err_dup=1, wr_count=16.
